// File: rtl/snn_clk_pkg.sv
// Shared types and helpers for the leak timebase generator.
// Provides channel-index width, reset exponent defaults and the config bundle.
package snn_clk_pkg;

  localparam int CH_W_MAX    = 8;
  localparam int SHIFT_W_MAX = 8;

  function automatic int CH_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Legacy /2,/4,/8,/16 phases come from k_i = i, clamped to the counter.
  function automatic int def_shift(input int ch, input int cnt_w);
    return (ch < cnt_w) ? ch : cnt_w;
  endfunction

  typedef struct packed {
    logic [CH_W_MAX-1:0]    ch;
    logic [SHIFT_W_MAX-1:0] shift;
    logic                   en;
  } cfg_req_t;

endpackage

// File: rtl/leak_tick_lane.sv
// One leak channel: exponent/enable registers, tick compare, tick and phase.
// Ports: cnt (shared counter), upd/upd_shift/upd_en (apply), cond/ch_en/tick/phase.
module leak_tick_lane
  import snn_clk_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int SHIFT_W = 5,
  parameter int RST_K   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               upd,
  input  logic [SHIFT_W-1:0] upd_shift,
  input  logic               upd_en,
  output logic               cond,
  output logic               ch_en,
  output logic               tick,
  output logic               phase
);

  logic [SHIFT_W-1:0] k_q, k_d;
  logic               ch_en_q, ch_en_d;
  logic               phase_q, phase_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   mask;

  // Bits below k must all be ones; k beyond CNT_W saturates naturally.
  always_comb begin
    mask = '0;
    for (int b = 0; b < CNT_W; b++) begin
      if (b < int'(k_q)) mask[b] = 1'b1;
    end
    cond = ch_en_q & ((cnt & mask) == mask);
  end

  always_comb begin
    k_d     = k_q;
    ch_en_d = ch_en_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (sync_clr) begin
      phase_d = 1'b0;
    end else if (en) begin
      tick_d  = cond;
      phase_d = phase_q ^ cond;
    end
    if (upd) begin
      k_d     = upd_shift;
      ch_en_d = upd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= SHIFT_W'(RST_K);
      ch_en_q <= 1'b1;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      ch_en_q <= ch_en_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign ch_en = ch_en_q;
  assign tick  = tick_q;
  assign phase = phase_q;

endmodule

// File: rtl/leak_tick_gen.sv
// Leak (beta) timebase: per-channel tick enables and phases from one counter.
// Ports: en, sync_clr, cfg_valid/ready/ch/shift/en handshake, tick, phase.
module leak_tick_gen
  import snn_clk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W(NUM_CH)-1:0]   cfg_ch,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_en,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         phase
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d;
  cfg_req_t          pend_q, pend_d;
  logic [NUM_CH-1:0] cond, ch_en, upd;
  logic              sel_cond, sel_en;
  logic              accept, apply;
  logic              unused_shift;

  assign unused_shift = ^pend_q.shift;
  assign cfg_ready    = ~pend_v_q;
  assign accept       = cfg_valid & cfg_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Apply at the target's old-k boundary, immediately if it is idle,
  // or on sync_clr. Apply requires a full slot, accept an empty one.
  always_comb begin
    sel_cond = 1'b0;
    sel_en   = 1'b0;
    upd      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(pend_q.ch) == i) begin
        sel_cond = cond[i];
        sel_en   = ch_en[i];
      end
    end
    apply = pend_v_q & (sync_clr | ~sel_en | (en & sel_cond));
    for (int i = 0; i < NUM_CH; i++) begin
      upd[i] = apply & (int'(pend_q.ch) == i);
    end
  end

  always_comb begin
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    if (apply) begin
      pend_v_d = 1'b0;
    end
    if (accept && (int'(cfg_ch) < NUM_CH)) begin
      pend_v_d     = 1'b1;
      pend_d.ch    = CH_W_MAX'(cfg_ch);
      pend_d.shift = SHIFT_W_MAX'(cfg_shift);
      pend_d.en    = cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    leak_tick_lane #(
      .CNT_W   (CNT_W),
      .SHIFT_W (SHIFT_W),
      .RST_K   (def_shift(g, CNT_W))
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sync_clr  (sync_clr),
      .cnt       (cnt_q),
      .upd       (upd[g]),
      .upd_shift (pend_q.shift[SHIFT_W-1:0]),
      .upd_en    (pend_q.en),
      .cond      (cond[g]),
      .ch_en     (ch_en[g]),
      .tick      (tick[g]),
      .phase     (phase[g])
    );
  end

endmodule

// File: tb/tb_leak_tick_gen.sv
// Bench for leak_tick_gen: two instances (CNT_W=16/NUM_CH=4, CNT_W=4/NUM_CH=5)
// compared every cycle against a cycle-count reference model.
module tb_leak_tick_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic sync_clr = 1'b0;

  logic       cv_a = 1'b0, ce_a = 1'b0;
  logic [1:0] cc_a = '0;
  logic [4:0] cs_a = '0;
  logic       rdy_a;
  logic [3:0] tick_a, phase_a;

  logic       cv_b = 1'b0, ce_b = 1'b0;
  logic [2:0] cc_b = '0;
  logic [4:0] cs_b = '0;
  logic       rdy_b;
  logic [4:0] tick_b, phase_b;

  logic [19:0] obs;
  assign obs = {rdy_b, phase_b, tick_b, rdy_a, phase_a, tick_a};

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  leak_tick_gen #(.NUM_CH(4), .CNT_W(16), .SHIFT_W(5)) u_a (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cv_a), .cfg_ready(rdy_a), .cfg_ch(cc_a),
    .cfg_shift(cs_a), .cfg_en(ce_a), .tick(tick_a), .phase(phase_a)
  );

  leak_tick_gen #(.NUM_CH(5), .CNT_W(4), .SHIFT_W(5)) u_b (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cv_b), .cfg_ready(rdy_b), .cfg_ch(cc_b),
    .cfg_shift(cs_b), .cfg_en(ce_b), .tick(tick_b), .phase(phase_b)
  );

  // Reference model: count of enabled cycles modulo 2^CNT_W,
  // tick when that count is one short of a multiple of 2^k.
  int cw[2] = '{16, 4};
  int nch[2] = '{4, 5};
  int mcnt[2];
  int mk[2][8];
  bit men[2][8], mph[2][8], mtk[2][8];
  bit pv[2], pen[2];
  int pch[2], psh[2];

  task automatic model_step(input int d, input bit v, input int ch,
                            input int sh, input bit e);
    bit cnd[8];
    bit app;
    bit acc;
    int ke, p;
    if (reset) begin
      mcnt[d] = 0;
      pv[d] = 0;
      for (int i = 0; i < 8; i++) begin
        mk[d][i] = (i < cw[d]) ? i : cw[d];
        men[d][i] = 1;
        mph[d][i] = 0;
        mtk[d][i] = 0;
      end
      return;
    end
    for (int i = 0; i < 8; i++) begin
      ke = (mk[d][i] < cw[d]) ? mk[d][i] : cw[d];
      p = 1 << ke;
      cnd[i] = (i < nch[d]) && men[d][i] && ((mcnt[d] % p) == p - 1);
    end
    app = pv[d] && (sync_clr || !men[d][pch[d]] || (en && cnd[pch[d]]));
    acc = v && !pv[d];
    for (int i = 0; i < nch[d]; i++) begin
      if (sync_clr) begin
        mtk[d][i] = 0;
        mph[d][i] = 0;
      end else if (en) begin
        mtk[d][i] = cnd[i];
        mph[d][i] = mph[d][i] ^ cnd[i];
      end else begin
        mtk[d][i] = 0;
      end
    end
    if (sync_clr) mcnt[d] = 0;
    else if (en) mcnt[d] = (mcnt[d] + 1) % (1 << cw[d]);
    if (app) begin
      mk[d][pch[d]] = psh[d];
      men[d][pch[d]] = pen[d];
      pv[d] = 0;
    end
    if (acc && ch < nch[d]) begin
      pv[d] = 1;
      pch[d] = ch;
      psh[d] = sh;
      pen[d] = e;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, cv_a, int'(cc_a), int'(cs_a), ce_a);
    model_step(1, cv_b, int'(cc_b), int'(cs_b), ce_b);
  end

  function automatic logic [19:0] exp_all();
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = mtk[0][i];
      r[4+i] = mph[0][i];
    end
    r[8] = !pv[0];
    for (int i = 0; i < 5; i++) begin
      r[9+i] = mtk[1][i];
      r[14+i] = mph[1][i];
    end
    r[19] = !pv[1];
    return r;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input int ch, input int sh, input bit e);
    cv_a = 1; cc_a = 2'(ch); cs_a = 5'(sh); ce_a = e;
    adv();
    cv_a = 0;
  endtask

  task automatic cfg_b(input int ch, input int sh, input bit e);
    cv_b = 1; cc_b = 3'(ch); cs_b = 5'(sh); ce_b = e;
    adv();
    cv_b = 0;
  endtask

  task automatic wait_rdy(input int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if ((d == 0) ? rdy_a : rdy_b) begin
        ok = 1;
        break;
      end
      adv();
    end
  endtask

  task automatic test_reset();
    reset = 1; en = 0;
    adv(); adv();
    n_run++;
    if (obs !== 20'h80100) begin
      n_fail++;
      $display("FAIL reset_const got=%h want=%h", obs, 20'h80100);
    end
    n_run++;
    if (obs !== exp_all()) begin
      n_fail++;
      $display("FAIL reset_model got=%h want=%h", obs, exp_all());
    end
  endtask

  task automatic test_default();
    int c1, c3, t3;
    bit p3;
    c1 = 0; c3 = 0; t3 = 0; p3 = 0;
    reset = 0; en = 1;
    for (int c = 0; c < 64; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL default c=%0d got=%h want=%h", c, obs, exp_all());
      end
      if (c == 0) begin
        n_run++;
        if (tick_a[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL first_tick0 got=%b want=1", tick_a[0]);
        end
      end
      c1 += int'(tick_a[1]);
      c3 += int'(tick_a[3]);
      if (phase_a[3] != p3) t3++;
      p3 = phase_a[3];
    end
    n_run++;
    if (c1 != 32 || c3 != 8 || t3 != 8) begin
      n_fail++;
      $display("FAIL default_counts got=%0d/%0d/%0d want=32/8/8", c1, c3, t3);
    end
  endtask

  task automatic test_reprogram();
    int last, gap, maxgap;
    last = -1; gap = 0; maxgap = 0;
    cfg_a(1, 4, 1);
    n_run++;
    if (rdy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reprog_pending got=%b want=0", rdy_a);
    end
    for (int c = 0; c < 80; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL reprog c=%0d got=%h want=%h", c, obs, exp_all());
      end
      if (tick_a[1]) begin
        if (last >= 0) begin
          gap = c - last;
          if (gap > maxgap) maxgap = gap;
        end
        last = c;
      end
    end
    n_run++;
    if (maxgap != 16 || gap != 16) begin
      n_fail++;
      $display("FAIL reprog_gap got=%0d/%0d want=16/16", maxgap, gap);
    end
  endtask

  task automatic test_disable();
    bit ok;
    bit p2;
    cfg_a(2, 2, 0);
    wait_rdy(0, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL disable_timeout got=0 want=1");
    end
    p2 = phase_a[2];
    for (int c = 0; c < 24; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all() || tick_a[2] !== 1'b0 || phase_a[2] !== p2) begin
        n_fail++;
        $display("FAIL disabled c=%0d got=%h want=%h", c, obs, exp_all());
      end
    end
    cfg_a(2, 0, 1);
    adv();
    n_run++;
    if (rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable_ready got=%b want=1", rdy_a);
    end
    for (int c = 0; c < 8; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all() || tick_a[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL reenable c=%0d got=%h want=%h", c, obs, exp_all());
      end
    end
  endtask

  task automatic test_toggle_en();
    bit ok;
    int n0;
    n0 = 0;
    cfg_a(0, 2, 1);
    wait_rdy(0, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL toggle_timeout got=0 want=1");
    end
    for (int c = 0; c < 64; c++) begin
      en = (c % 2 == 0);
      adv();
      n0 += int'(tick_a[0]);
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL toggle c=%0d got=%h want=%h", c, obs, exp_all());
      end
    end
    en = 1;
    n_run++;
    if (n0 != 8) begin
      n_fail++;
      $display("FAIL toggle_count got=%0d want=8", n0);
    end
  endtask

  task automatic test_sync_clr();
    int first;
    first = -1;
    cfg_a(3, 6, 1);
    en = 0;
    for (int c = 0; c < 5; c++) begin
      adv();
      n_run++;
      if (rdy_a !== 1'b0 || obs !== exp_all()) begin
        n_fail++;
        $display("FAIL stall c=%0d got=%h want=%h", c, obs, exp_all());
      end
    end
    sync_clr = 1;
    adv();
    sync_clr = 0;
    n_run++;
    if (tick_a !== 4'h0 || phase_a !== 4'h0 || rdy_a !== 1'b1
        || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL sync_clr got=%h want=%h", obs, exp_all());
    end
    en = 1;
    for (int c = 1; c <= 80; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL post_sync c=%0d got=%h want=%h", c, obs, exp_all());
      end
      if (tick_a[3] && first < 0) first = c;
    end
    n_run++;
    if (first != 64) begin
      n_fail++;
      $display("FAIL sync_first_tick got=%0d want=64", first);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int last, nt, bad;
    last = -1; nt = 0; bad = 0;
    cfg_b(5, 3, 0);
    n_run++;
    if (rdy_b !== 1'b1 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL oob_write got=%h want=%h", obs, exp_all());
    end
    cfg_b(0, 31, 1);
    wait_rdy(1, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clamp_timeout got=0 want=1");
    end
    for (int c = 0; c < 70; c++) begin
      adv();
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL clamp c=%0d got=%h want=%h", c, obs, exp_all());
      end
      if (tick_b[0]) begin
        if (last >= 0 && c - last != 16) bad++;
        last = c;
        nt++;
      end
    end
    n_run++;
    if (bad != 0 || nt < 4) begin
      n_fail++;
      $display("FAIL clamp_period got=%0d/%0d want=0/>=4", bad, nt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 49) == 0);
      cv_a = ($urandom_range(0, 5) == 0);
      cc_a = 2'($urandom_range(0, 3));
      cs_a = 5'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                           : $urandom_range(0, 5));
      ce_a = ($urandom_range(0, 5) != 0);
      cv_b = ($urandom_range(0, 5) == 0);
      cc_b = 3'($urandom_range(0, 7));
      cs_b = 5'($urandom_range(0, 31));
      ce_b = ($urandom_range(0, 5) != 0);
      adv();
      n_run++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_all());
      end
    end
    reset = 0; sync_clr = 0; cv_a = 0; cv_b = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_default();
    test_reprogram();
    test_disable();
    test_toggle_en();
    test_sync_clr();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
